// File: rtl/sram_sequencer.sv
// Registered SETUP/STROBE/HOLD sequencer for a 16-bit asynchronous SRAM.
// Define SRAM_SEQ_BYTE_MASK_EN to drive UbN/LbN from the request byte enables.
module sram_sequencer #(
    parameter int ADDR_W     = 18,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_reqValid,
    output logic              o_reqReady,
    input  logic              i_reqWr,
    input  logic [ADDR_W-1:0] i_reqAddr,
    input  logic [15:0]       i_reqData,
    input  logic [1:0]        i_reqByteEn,
    output logic              o_rspValid,
    output logic [15:0]       o_rspData,
    output logic [ADDR_W-1:0] o_sramAddr,
    output logic [15:0]       o_sramDqOut,
    output logic              o_sramDqOe,
    input  logic [15:0]       i_sramDqIn,
    output logic              o_sramWeN,
    output logic              o_sramOeN,
    output logic              o_sramCeN,
    output logic              o_sramUbN,
    output logic              o_sramLbN
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
        $error("sram_sequencer: SETUP_CYC must be 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
        $error("sram_sequencer: STROBE_CYC must be 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
        $error("sram_sequencer: HOLD_CYC must be 1..15");
    end

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] phase_q;
    logic       wr_q;
    logic       phase_done;
    logic       accept;
    logic       ub_n_acc;
    logic       lb_n_acc;

    assign o_reqReady = (state_q == IDLE);
    assign accept     = i_reqValid && o_reqReady;
    assign phase_done = (phase_q == 4'd0);

`ifdef SRAM_SEQ_BYTE_MASK_EN
    assign ub_n_acc = ~i_reqByteEn[1];
    assign lb_n_acc = ~i_reqByteEn[0];
`else
    logic unused_byte_en;
    assign unused_byte_en = ^i_reqByteEn;
    assign ub_n_acc = 1'b0;
    assign lb_n_acc = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = SETUP;
            SETUP:   if (phase_done) state_d = STROBE;
            STROBE:  if (phase_done) state_d = HOLD;
            HOLD:    if (phase_done) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            phase_q     <= 4'd0;
            wr_q        <= 1'b0;
            o_rspValid  <= 1'b0;
            o_rspData   <= 16'h0000;
            o_sramAddr  <= '0;
            o_sramDqOut <= 16'h0000;
            o_sramDqOe  <= 1'b0;
            o_sramWeN   <= 1'b1;
            o_sramOeN   <= 1'b1;
            o_sramCeN   <= 1'b1;
            o_sramUbN   <= 1'b1;
            o_sramLbN   <= 1'b1;
        end else begin
            state_q    <= state_d;
            o_rspValid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_q        <= i_reqWr;
                        o_sramAddr  <= i_reqAddr;
                        o_sramDqOut <= i_reqData;
                        o_sramDqOe  <= i_reqWr;
                        o_sramCeN   <= 1'b0;
                        o_sramUbN   <= ub_n_acc;
                        o_sramLbN   <= lb_n_acc;
                        phase_q     <= SETUP_LD;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        phase_q   <= STROBE_LD;
                        o_sramWeN <= ~wr_q;
                        o_sramOeN <= wr_q;
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                STROBE: begin
                    if (phase_done) begin
                        phase_q    <= HOLD_LD;
                        o_sramWeN  <= 1'b1;
                        o_sramOeN  <= 1'b1;
                        o_rspValid <= 1'b1;
                        // Sample DQ while OeN is still low on this edge
                        if (!wr_q) o_rspData <= i_sramDqIn;
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        o_sramCeN  <= 1'b1;
                        o_sramUbN  <= 1'b1;
                        o_sramLbN  <= 1'b1;
                        o_sramDqOe <= 1'b0;
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_sequencer.sv
// Directed self-checking bench for sram_sequencer with a small SRAM model.
// Byte-mask steps build only when SRAM_SEQ_BYTE_MASK_EN is defined.
module tb_sram_sequencer;

    logic        pll_clkQ = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [17:0] req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [17:0] sram_addr;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] dq_in;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [15:0] mem [256];

    always #5 pll_clkQ = ~pll_clkQ;

    sram_sequencer dut (
        .i_clk       (pll_clkQ),
        .i_rstn      (rst_n),
        .i_reqValid  (req_valid),
        .o_reqReady  (req_ready),
        .i_reqWr     (req_wr),
        .i_reqAddr   (req_addr),
        .i_reqData   (req_data),
        .i_reqByteEn (req_be),
        .o_rspValid  (rsp_valid),
        .o_rspData   (rsp_data),
        .o_sramAddr  (sram_addr),
        .o_sramDqOut (dq_out),
        .o_sramDqOe  (dq_oe),
        .i_sramDqIn  (dq_in),
        .o_sramWeN   (we_n),
        .o_sramOeN   (oe_n),
        .o_sramCeN   (ce_n),
        .o_sramUbN   (ub_n),
        .o_sramLbN   (lb_n)
    );

    assign dq_in = (!oe_n && !ce_n) ? mem[sram_addr[7:0]] : 16'h0000;

    always @(posedge pll_clkQ) begin
        if (!ce_n && !we_n && dq_oe) begin
            if (!lb_n) mem[sram_addr[7:0]][7:0]  <= dq_out[7:0];
            if (!ub_n) mem[sram_addr[7:0]][15:8] <= dq_out[15:8];
        end
    end

    always @(negedge pll_clkQ) begin
        if (!we_n && !oe_n) viol++;
        if (dq_oe && !oe_n) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pll_clkQ);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [17:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        req_wr   = wr;
        req_addr = a;
        req_data = d;
        req_be   = be;
    endtask

    logic [15:0] b2b_data [4];
    int          b2b_cyc  [4];
    int          npulse;
    int          k;
    logic        fire;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_n = 1'b0;
        req_valid = 1'b0;
        drive(1'b0, 18'h0, 16'h0, 2'b11);

        // reset held for 3 cycles
        step();
        chk("rst_ready", req_ready, 1);
        step();
        step();
        chk("rst_ctl", {we_n, oe_n, ce_n, ub_n, lb_n}, 5'b11111);
        chk("rst_oe", dq_oe, 0);
        chk("rst_rsp", {rsp_valid, rsp_data}, 17'h0);
        chk("rst_addr", {sram_addr, dq_out}, 34'h0);
        @(negedge pll_clkQ);
        rst_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid) npulse++;
        end
        chk("idle_norsp", npulse, 0);
        chk("idle_ready", req_ready, 1);

        // write 0xBEEF to 0x00123
        drive(1'b1, 18'h00123, 16'hBEEF, 2'b11);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("w_c1", {ce_n, we_n, oe_n, dq_oe, req_ready, rsp_valid}, 6'b011100);
        chk("w_c1_bus", {sram_addr, dq_out}, {18'h00123, 16'hBEEF});
        chk("w_c1_be", {ub_n, lb_n}, 2'b00);
        step();
        chk("w_c2", {ce_n, we_n, oe_n, dq_oe, rsp_valid}, 5'b00110);
        step();
        chk("w_c3", {ce_n, we_n, oe_n, dq_oe, rsp_valid}, 5'b00110);
        step();
        chk("w_c4", {ce_n, we_n, oe_n, dq_oe, rsp_valid, req_ready}, 6'b011110);
        chk("w_c4_bus", {sram_addr, dq_out}, {18'h00123, 16'hBEEF});
        step();
        chk("w_c5", {ce_n, ub_n, lb_n, dq_oe, rsp_valid, req_ready}, 6'b111001);
        chk("w_mem", mem[8'h23], 16'hBEEF);

        // read 0x5A5A from 0x00123
        mem[8'h23] = 16'h5A5A;
        drive(1'b0, 18'h00123, 16'h0000, 2'b11);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("r_c1", {ce_n, we_n, oe_n, dq_oe}, 4'b0110);
        step();
        chk("r_c2", {ce_n, we_n, oe_n, dq_oe}, 4'b0100);
        step();
        chk("r_c3", {ce_n, we_n, oe_n, dq_oe, rsp_valid}, 5'b01000);
        step();
        chk("r_c4", {ce_n, we_n, oe_n, rsp_valid}, 4'b0111);
        chk("r_data", rsp_data, 16'h5A5A);
        step();
        chk("r_c5", {ce_n, rsp_valid, req_ready}, 3'b101);
        chk("r_hold", rsp_data, 16'h5A5A);

        // back-to-back with valid held high
        k = 0;
        npulse = 0;
        drive(1'b1, 18'h00001, 16'h1111, 2'b11);
        req_valid = 1'b1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            fire = req_ready && req_valid;
            step();
            if (fire) begin
                k++;
                case (k)
                    1: drive(1'b0, 18'h00001, 16'h0000, 2'b11);
                    2: drive(1'b1, 18'h00002, 16'h2222, 2'b11);
                    3: drive(1'b0, 18'h00002, 16'h0000, 2'b11);
                    default: req_valid = 1'b0;
                endcase
            end
            if (rsp_valid) begin
                if (npulse < 4) begin
                    b2b_cyc[npulse]  = cyc;
                    b2b_data[npulse] = rsp_data;
                end
                npulse++;
            end
        end
        chk("b2b_count", npulse, 4);
        chk("b2b_accepts", k, 4);
        chk("b2b_t0", b2b_cyc[0], 4);
        chk("b2b_gap1", b2b_cyc[1] - b2b_cyc[0], 5);
        chk("b2b_gap2", b2b_cyc[2] - b2b_cyc[1], 5);
        chk("b2b_gap3", b2b_cyc[3] - b2b_cyc[2], 5);
        chk("b2b_rd1", b2b_data[1], 16'h1111);
        chk("b2b_rd2", b2b_data[3], 16'h2222);

        // reset asserted while in STROBE of a write
        drive(1'b1, 18'h00040, 16'hCAFE, 2'b11);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("mr_strobe", {ce_n, we_n}, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async", {we_n, oe_n, ce_n, ub_n, lb_n, dq_oe}, 6'b111110);
        chk("mr_ready", req_ready, 1);
        chk("mr_rsp", {rsp_valid, rsp_data}, 17'h0);
        npulse = 0;
        step();
        if (rsp_valid) npulse++;
        @(negedge pll_clkQ);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) npulse++;
        end
        chk("mr_norsp", npulse, 0);
        drive(1'b0, 18'h00002, 16'h0000, 2'b11);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        chk("mr_next", {rsp_valid, rsp_data}, {1'b1, 16'h2222});

`ifdef SRAM_SEQ_BYTE_MASK_EN
        mem[8'h50] = 16'hFFFF;
        drive(1'b1, 18'h00050, 16'h1234, 2'b01);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("bm01_c1", {ub_n, lb_n}, 2'b10);
        step();
        step();
        chk("bm01_c3", {ub_n, lb_n, we_n}, 3'b100);
        step();
        chk("bm01_c4", {ub_n, lb_n, rsp_valid}, 3'b101);
        step();
        chk("bm01_mem", mem[8'h50], 16'hFF34);
        drive(1'b1, 18'h00050, 16'h0000, 2'b00);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("bm00_c1", {ce_n, ub_n, lb_n}, 3'b011);
        step();
        step();
        step();
        chk("bm00_c4", {ub_n, lb_n, rsp_valid}, 3'b111);
        step();
        chk("bm00_mem", mem[8'h50], 16'hFF34);
`endif

        chk("no_overlap", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
